// File: rtl/probe_spec_pkg.sv
// Shared defaults and the reference-model step function for the probe/override block.
package probe_spec_pkg;

  localparam int             WIDTH_DEF       = 8;
  localparam int             CYCLE_W_DEF     = 16;
  localparam logic [7:0]     FORCE_VALUE_DEF = 8'hA5;

  // Value the probed counter shows on the cycle after i_cycle, derived from the
  // cycle index and the previous model value only (never from the real counter).
  //   - next cycle inside the window          -> force value
  //   - current cycle inside the window       -> register captured the force value
  //   - otherwise                              -> previous value + 1
  function automatic logic [31:0] next_expected(
    input logic [31:0] i_cycle,
    input logic [31:0] i_prev,
    input logic [31:0] i_start,
    input logic [31:0] i_stop,
    input logic [31:0] i_value
  );
    logic [31:0] w_next;
    w_next = i_cycle + 32'd1;
    if ((w_next >= i_start) && (w_next < i_stop))
      return i_value;
    if ((i_cycle >= i_start) && (i_cycle < i_stop))
      return i_value;
    return i_prev + 32'd1;
  endfunction

endpackage

// File: rtl/probe_spec_if.sv
// Observation bundle for the probe block's internal nets; the master side
// drives them, the slave side only watches.
interface probe_spec_if
  import probe_spec_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int CYCLE_W = CYCLE_W_DEF
);
  logic [CYCLE_W-1:0] cycle;
  logic               force_en;
  logic [WIDTH-1:0]   probe_value;
  logic [WIDTH-1:0]   expected;
  logic               err;
  logic               done;

  modport master (output cycle, force_en, probe_value, expected, err, done);
  modport slave  (input  cycle, force_en, probe_value, expected, err, done);
endinterface

// File: rtl/probe_spec_counter.sv
// Free-running counter with a force override; the override shows on the probe
// in the same cycle it is requested and is captured by the register.
module probe_spec_counter
  import probe_spec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             force_en,
  input  logic [WIDTH-1:0] force_value,
  output logic [WIDTH-1:0] probe_value
);

  logic [WIDTH-1:0] count_q;

  // Count up (wrapping), or load the force value while overridden.
  always_ff @(posedge clock) begin
    if (reset)
      count_q <= '0;
    else if (force_en)
      count_q <= force_value;
    else
      count_q <= count_q + 1'b1;
  end

  // Probe mux: forced value wins combinationally.
  always_comb probe_value = force_en ? force_value : count_q;

endmodule

// File: rtl/probe_spec.sv
// Probe/override exercise: cycle sequencer forces the counter for a window,
// a reference model tracks it from the cycle index, and a checker compares.
module probe_spec
  import probe_spec_pkg::*;
#(
  parameter int               WIDTH       = WIDTH_DEF,
  parameter int               CYCLE_W     = CYCLE_W_DEF,
  parameter int               FORCE_START = 10,
  parameter int               FORCE_END   = 20,
  parameter logic [WIDTH-1:0] FORCE_VALUE = WIDTH'(FORCE_VALUE_DEF),
  parameter int               DONE_CYCLE  = 24
) (
  input logic clock,
  input logic reset
);

  localparam logic [CYCLE_W-1:0] CYCLE_MAX = '1;

  logic [CYCLE_W-1:0] cycle;
  logic               force_en;
  logic [WIDTH-1:0]   probe_value;
  logic [WIDTH-1:0]   expected;
  logic               err;
  logic               done;

  logic [CYCLE_W-1:0] w_cycle_next;
  logic [WIDTH-1:0]   w_expected_next;
  logic               w_check_en;
  logic               w_mismatch;
  logic               w_done_set;

  probe_spec_counter #(.WIDTH(WIDTH)) u_counter (
    .clock       (clock),
    .reset       (reset),
    .force_en    (force_en),
    .force_value (FORCE_VALUE),
    .probe_value (probe_value)
  );

  // Sequencer decode, reference step and checker conditions.
  always_comb begin
    w_cycle_next    = (cycle == CYCLE_MAX) ? cycle : cycle + 1'b1;
    force_en        = (32'(cycle) >= 32'(FORCE_START)) && (32'(cycle) < 32'(FORCE_END));
    w_expected_next = WIDTH'(next_expected(32'(cycle), 32'(expected), 32'(FORCE_START),
                                           32'(FORCE_END), 32'(FORCE_VALUE)));
    w_check_en      = 32'(cycle) < 32'(DONE_CYCLE);
    w_mismatch      = w_check_en && (probe_value != expected);
    // done is raised on the edge that enters DONE_CYCLE so it reads 1 at that cycle.
    w_done_set      = 32'(w_cycle_next) >= 32'(DONE_CYCLE);
  end

  // Cycle counter, reference model, sticky error and completion flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle    <= '0;
      expected <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      cycle    <= w_cycle_next;
      expected <= w_expected_next;
      if (w_mismatch) begin
        err <= 1'b1;
        $error("probe mismatch at cycle %0d: probe_value=%h expected=%h",
               cycle, probe_value, expected);
      end
      if (w_done_set && !done) begin
        done <= 1'b1;
        // Include a mismatch caught on this same edge in the verdict.
        if (err || w_mismatch)
          $error("FAIL");
        else
          $info("PASS");
      end
    end
  end

endmodule

// File: tb/tb_probe_spec.sv
module tb_probe_spec;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   t        = 0;

  always #5 clock = ~clock;

  probe_spec dut (
    .clock (clock),
    .reset (reset)
  );

  probe_spec #(
    .FORCE_START (10),
    .FORCE_END   (12),
    .FORCE_VALUE (8'hFE)
  ) dut_w (
    .clock (clock),
    .reset (reset)
  );

  probe_spec_if #(.WIDTH(8), .CYCLE_W(16)) mon ();
  assign mon.cycle       = dut.cycle;
  assign mon.force_en    = dut.force_en;
  assign mon.probe_value = dut.probe_value;
  assign mon.expected    = dut.expected;
  assign mon.err         = dut.err;
  assign mon.done        = dut.done;

  task automatic tick();
    @(posedge clock);
    #1;
    t++;
  endtask

  task automatic run_to(input int n);
    while (t < n) tick();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    t = 0;
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++; if (mon.cycle !== 16'd0) begin failures++; $display("FAIL reset_cycle got=%0d want=0", mon.cycle); end
    checks++; if (mon.probe_value !== 8'h00) begin failures++; $display("FAIL reset_probe got=%h want=00", mon.probe_value); end
    checks++; if (mon.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", mon.err); end
    checks++; if (mon.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", mon.done); end
    run_to(5);
    checks++; if (mon.cycle !== 16'd5) begin failures++; $display("FAIL cycle5 got=%0d want=5", mon.cycle); end
    checks++; if (mon.probe_value !== 8'h05) begin failures++; $display("FAIL probe_c5 got=%h want=05", mon.probe_value); end
  endtask

  task automatic test_force_window();
    run_to(9);
    checks++; if (mon.probe_value !== 8'h09) begin failures++; $display("FAIL probe_c9 got=%h want=09", mon.probe_value); end
    checks++; if (mon.force_en !== 1'b0) begin failures++; $display("FAIL force_en_c9 got=%b want=0", mon.force_en); end
    run_to(10);
    checks++; if (mon.force_en !== 1'b1) begin failures++; $display("FAIL force_en_c10 got=%b want=1", mon.force_en); end
    checks++; if (mon.probe_value !== 8'hA5) begin failures++; $display("FAIL probe_c10 got=%h want=a5", mon.probe_value); end
    for (int c = 11; c <= 19; c++) begin
      run_to(c);
      checks++; if (mon.probe_value !== 8'hA5) begin failures++; $display("FAIL probe_hold_c%0d got=%h want=a5", c, mon.probe_value); end
    end
    checks++; if (mon.force_en !== 1'b1) begin failures++; $display("FAIL force_en_c19 got=%b want=1", mon.force_en); end
  endtask

  task automatic test_release();
    run_to(20);
    checks++; if (mon.force_en !== 1'b0) begin failures++; $display("FAIL force_en_c20 got=%b want=0", mon.force_en); end
    checks++; if (mon.probe_value !== 8'hA5) begin failures++; $display("FAIL probe_c20 got=%h want=a5", mon.probe_value); end
    run_to(21);
    checks++; if (mon.probe_value !== 8'hA6) begin failures++; $display("FAIL probe_c21 got=%h want=a6", mon.probe_value); end
    run_to(23);
    checks++; if (mon.probe_value !== 8'hA8) begin failures++; $display("FAIL probe_c23 got=%h want=a8", mon.probe_value); end
    checks++; if (mon.expected !== 8'hA8) begin failures++; $display("FAIL expected_c23 got=%h want=a8", mon.expected); end
    checks++; if (mon.done !== 1'b0) begin failures++; $display("FAIL done_c23 got=%b want=0", mon.done); end
  endtask

  task automatic test_done();
    run_to(24);
    checks++; if (mon.done !== 1'b1) begin failures++; $display("FAIL done_c24 got=%b want=1", mon.done); end
    checks++; if (mon.err !== 1'b0) begin failures++; $display("FAIL err_c24 got=%b want=0", mon.err); end
    run_to(30);
    checks++; if (mon.done !== 1'b1) begin failures++; $display("FAIL done_c30 got=%b want=1", mon.done); end
    checks++; if (mon.cycle !== 16'd30) begin failures++; $display("FAIL cycle30 got=%0d want=30", mon.cycle); end
    checks++; if (mon.probe_value !== 8'hAF) begin failures++; $display("FAIL probe_c30 got=%h want=af", mon.probe_value); end
  endtask

  task automatic test_mid_reset();
    do_reset(3);
    run_to(15);
    checks++; if (mon.probe_value !== 8'hA5) begin failures++; $display("FAIL mid_probe_c15 got=%h want=a5", mon.probe_value); end
    do_reset(2);
    checks++; if (mon.cycle !== 16'd0) begin failures++; $display("FAIL mid_cycle got=%0d want=0", mon.cycle); end
    checks++; if (mon.probe_value !== 8'h00) begin failures++; $display("FAIL mid_probe got=%h want=00", mon.probe_value); end
    checks++; if (mon.err !== 1'b0) begin failures++; $display("FAIL mid_err got=%b want=0", mon.err); end
    checks++; if (mon.done !== 1'b0) begin failures++; $display("FAIL mid_done got=%b want=0", mon.done); end
    checks++; if (mon.force_en !== 1'b0) begin failures++; $display("FAIL mid_force_en got=%b want=0", mon.force_en); end
    run_to(9);
    checks++; if (mon.probe_value !== 8'h09) begin failures++; $display("FAIL mid_probe_c9 got=%h want=09", mon.probe_value); end
    run_to(10);
    checks++; if (mon.probe_value !== 8'hA5) begin failures++; $display("FAIL mid_probe_c10 got=%h want=a5", mon.probe_value); end
    run_to(19);
    checks++; if (mon.probe_value !== 8'hA5) begin failures++; $display("FAIL mid_probe_c19 got=%h want=a5", mon.probe_value); end
    run_to(21);
    checks++; if (mon.probe_value !== 8'hA6) begin failures++; $display("FAIL mid_probe_c21 got=%h want=a6", mon.probe_value); end
    run_to(24);
    checks++; if (mon.done !== 1'b1) begin failures++; $display("FAIL mid_done_c24 got=%b want=1", mon.done); end
    checks++; if (mon.err !== 1'b0) begin failures++; $display("FAIL mid_err_c24 got=%b want=0", mon.err); end
  endtask

  task automatic test_wrap();
    do_reset(3);
    run_to(9);
    checks++; if (dut_w.probe_value !== 8'h09) begin failures++; $display("FAIL wrap_probe_c9 got=%h want=09", dut_w.probe_value); end
    run_to(10);
    checks++; if (dut_w.probe_value !== 8'hFE) begin failures++; $display("FAIL wrap_probe_c10 got=%h want=fe", dut_w.probe_value); end
    run_to(11);
    checks++; if (dut_w.probe_value !== 8'hFE) begin failures++; $display("FAIL wrap_probe_c11 got=%h want=fe", dut_w.probe_value); end
    run_to(12);
    checks++; if (dut_w.probe_value !== 8'hFE) begin failures++; $display("FAIL wrap_probe_c12 got=%h want=fe", dut_w.probe_value); end
    checks++; if (dut_w.force_en !== 1'b0) begin failures++; $display("FAIL wrap_force_en_c12 got=%b want=0", dut_w.force_en); end
    run_to(13);
    checks++; if (dut_w.probe_value !== 8'hFF) begin failures++; $display("FAIL wrap_probe_c13 got=%h want=ff", dut_w.probe_value); end
    run_to(14);
    checks++; if (dut_w.probe_value !== 8'h00) begin failures++; $display("FAIL wrap_probe_c14 got=%h want=00", dut_w.probe_value); end
    run_to(15);
    checks++; if (dut_w.probe_value !== 8'h01) begin failures++; $display("FAIL wrap_probe_c15 got=%h want=01", dut_w.probe_value); end
    run_to(24);
    checks++; if (dut_w.err !== 1'b0) begin failures++; $display("FAIL wrap_err got=%b want=0", dut_w.err); end
    checks++; if (dut_w.done !== 1'b1) begin failures++; $display("FAIL wrap_done got=%b want=1", dut_w.done); end
  endtask

  initial begin
    test_reset();
    test_force_window();
    test_release();
    test_done();
    test_mid_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
